// File: rtl/instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_loader
//  Description : Streams a program image into instruction memory one byte at
//                a time and holds the CPU core in reset until the image is
//                complete and valid.
//
//  Ports
//    clk         in   1   rising-edge clock for all state
//    rst         in   1   asynchronous active-low reset
//    start       in   1   load request, honoured only in IDLE/DONE/ERR
//    base_addr   in  32   byte address of first word (must be word aligned)
//    word_count  in  16   number of 32-bit words to load (must be non-zero)
//    byte_data   in   8   incoming program byte
//    byte_valid  in   1   byte_data is valid
//    byte_ready  out  1   byte accepted this cycle when byte_valid is high
//    mem_we      out  1   instruction-memory write strobe, one cycle per word
//    mem_addr    out 32   instruction-memory byte address
//    mem_wdata   out 32   instruction word to write
//    busy        out  1   load in progress (LOAD or WRITE)
//    done        out  1   sticky load-complete flag
//    err         out  1   sticky load-failed flag
//    core_rst_n  out  1   active-low core reset, released only after DONE
//
//  Revision    : 1.0  initial release
// ============================================================================
module instr_loader #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] base_addr,
    input  logic [15:0] word_count,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        core_rst_n
);

    // Idle-cycle count at which the timeout fires: the counter holds the
    // number of idle cycles already seen, so the TIMEOUT_CYCLES-th idle
    // cycle is the one that observes this value.
    localparam logic [31:0] C_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    // Load context captured on an accepted start
    logic [31:0]  r_base;
    logic [15:0]  r_count;

    // Progress counters
    logic [15:0]  r_word_idx;
    logic [1:0]   r_byte_idx;
    logic [31:0]  r_tcnt;

    // The first three bytes of a word; the fourth goes straight to the
    // write-data register together with these.
    logic [23:0]  r_word_buf;

    logic [31:0]  r_mem_addr;
    logic [31:0]  r_mem_wdata;
    logic         r_done;
    logic         r_err;

    logic         w_start_ok;
    logic         w_cfg_bad;
    logic         w_accept;
    logic         w_word_full;
    logic         w_timeout;
    logic         w_last_word;
    logic [31:0]  w_word_addr;

    // ------------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------------
    assign w_start_ok  = start && ((r_state == S_IDLE) ||
                                   (r_state == S_DONE) ||
                                   (r_state == S_ERR));
    assign w_cfg_bad   = (base_addr[1:0] != 2'b00) || (word_count == 16'd0);
    assign w_accept    = (r_state == S_LOAD) && byte_valid;
    assign w_word_full = w_accept && (r_byte_idx == 2'd3);
    assign w_timeout   = (r_state == S_LOAD) && !byte_valid &&
                         (r_tcnt == C_TMO_LAST);
    assign w_last_word = ((r_word_idx + 16'd1) == r_count);
    // Word index scaled to bytes; the add wraps at 2^32 by construction.
    assign w_word_addr = r_base + {14'd0, r_word_idx, 2'b00};

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_start_ok) begin
                    w_state_nxt = w_cfg_bad ? S_ERR : S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_word_full) begin
                    w_state_nxt = S_WRITE;
                end else if (w_timeout) begin
                    w_state_nxt = S_ERR;
                end
            end
            S_WRITE: begin
                w_state_nxt = w_last_word ? S_DONE : S_LOAD;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath, counters and sticky flags
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base      <= 32'd0;
            r_count     <= 16'd0;
            r_word_idx  <= 16'd0;
            r_byte_idx  <= 2'd0;
            r_tcnt      <= 32'd0;
            r_word_buf  <= 24'd0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_base     <= base_addr;
                r_count    <= word_count;
                r_word_idx <= 16'd0;
                r_byte_idx <= 2'd0;
                r_tcnt     <= 32'd0;
                r_done     <= 1'b0;
                // A rejected configuration goes straight to ERR, so the
                // flag is raised in the same edge that clears done.
                r_err      <= w_cfg_bad;
            end

            if (r_state == S_LOAD) begin
                if (w_accept) begin
                    r_tcnt     <= 32'd0;
                    r_byte_idx <= r_byte_idx + 2'd1;
                    case (r_byte_idx)
                        2'd0:    r_word_buf[7:0]   <= byte_data;
                        2'd1:    r_word_buf[15:8]  <= byte_data;
                        2'd2:    r_word_buf[23:16] <= byte_data;
                        default: begin
                            // Complete word: present address and data for
                            // the WRITE cycle. These registers only change
                            // here, so they hold between strobes.
                            r_mem_addr  <= w_word_addr;
                            r_mem_wdata <= {byte_data, r_word_buf};
                        end
                    endcase
                end else if (w_timeout) begin
                    // Partial word is abandoned; nothing reaches memory.
                    r_err <= 1'b1;
                end else begin
                    r_tcnt <= r_tcnt + 32'd1;
                end
            end

            if (r_state == S_WRITE) begin
                r_word_idx <= r_word_idx + 16'd1;
                if (w_last_word) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign byte_ready = (r_state == S_LOAD);
    // Strobe is derived from the state, so an asynchronous reset taken
    // while a word is waiting to be written cancels that write outright.
    assign mem_we     = (r_state == S_WRITE);
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign busy       = (r_state == S_LOAD) || (r_state == S_WRITE);
    assign done       = r_done;
    assign err        = r_err;
    // The core only runs on a fully written image.
    assign core_rst_n = r_done;

endmodule
`default_nettype wire

// File: tb/tb_instr_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_loader
//  Description : Self-checking bench for instr_loader. A monitor compares the
//                DUT against a byte-counting model every cycle; directed
//                tests add literal expectations for each scenario.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_loader;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = 32'd0;
    logic [15:0] word_count = 16'd0;
    logic [7:0]  byte_data = 8'd0;
    logic        byte_valid = 1'b0;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_rst_n;

    instr_loader #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .byte_data  (byte_data),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .core_rst_n (core_rst_n)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    logic [7:0]  bq[$];
    bit          we_due = 1'b0;
    int          acc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Little-endian word w of the byte image in bq.
    function automatic logic [31:0] model_word(input int w);
        return {bq[4*w+3], bq[4*w+2], bq[4*w+1], bq[4*w]};
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: mid-cycle comparison against the model
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("reset_flags", {byte_ready, mem_we, busy, done, err, core_rst_n}, 6'd0);
                check("reset_addr_data", {mem_addr, mem_wdata}, 64'd0);
                we_due = 1'b0;
                acc    = 0;
            end else begin
                check("mem_we_timing", mem_we, we_due);
                if (mem_we) begin
                    check("ready_in_write", byte_ready, 1'b0);
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write actual_addr=0x%0h actual_data=0x%0h required=no_write",
                                 mem_addr, mem_wdata);
                    end else begin
                        check("write_addr", mem_addr, exp_addr_q.pop_front());
                        check("write_data", mem_wdata, exp_data_q.pop_front());
                    end
                end
                check("done_err_exclusive", done & err, 1'b0);
                check("ready_outside_busy", byte_ready & ~busy, 1'b0);
                // Predict the strobe for the next cycle: every fourth byte
                // accepted since the last accepted start completes a word.
                we_due = 1'b0;
                if (start && !busy) acc = 0;
                if (byte_valid && byte_ready) begin
                    acc++;
                    if (acc == 4) begin
                        we_due = 1'b1;
                        acc    = 0;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------------
    task automatic do_start(input logic [31:0] b, input logic [15:0] c);
        @(posedge clk); #2;
        start      = 1'b1;
        base_addr  = b;
        word_count = c;
        @(posedge clk); #2;
        start      = 1'b0;
    endtask

    // Offers bq[first .. first+n-1]; returns just after the last acceptance.
    task automatic send(input int first, input int n, input bit rnd);
        int  i = 0;
        int  budget = 0;
        logic rdy;
        @(posedge clk); #2;
        while (i < n) begin
            if (budget >= 500) begin
                checks++;
                failures++;
                $display("FAIL send_budget actual_sent=%0d required=%0d", i, n);
                break;
            end
            byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            byte_data  = bq[first + i];
            @(negedge clk);
            rdy = byte_ready;
            @(posedge clk);
            if (byte_valid && rdy) i++;
            budget++;
            #2;
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_end(input string name, input bit exp_done);
        int n = 0;
        @(negedge clk);
        while (!(done || err) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({name, "_flags"}, {done, err, core_rst_n, busy}, {exp_done, ~exp_done, exp_done, 1'b0});
        check({name, "_writes_left"}, exp_addr_q.size(), 0);
    endtask

    // ------------------------------------------------------------------------
    // Directed scenarios
    // ------------------------------------------------------------------------
    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_after_reset", {busy, done, err, core_rst_n, byte_ready, mem_we}, 6'd0);

        // Two-word load with literal results
        bq = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        check("model_pin_w0", model_word(0), 32'h0000_0013);
        check("model_pin_w1", model_word(1), 32'h0010_0093);
        exp_addr_q.push_back(32'h100); exp_data_q.push_back(32'h0000_0013);
        exp_addr_q.push_back(32'h104); exp_data_q.push_back(32'h0010_0093);
        do_start(32'h100, 16'd2);
        send(0, 8, 1'b0);
        wait_end("basic", 1'b1);
        repeat (5) @(negedge clk);
        check("done_sticky", {done, core_rst_n, err}, 3'b110);

        // Misaligned base from DONE, then zero count from ERR
        do_start(32'h102, 16'd1);
        @(negedge clk);
        check("misaligned_err", {done, err, core_rst_n, busy}, 4'b0100);
        repeat (4) @(negedge clk);
        check("misaligned_hold", {done, err, core_rst_n}, 3'b010);
        do_start(32'h200, 16'd0);
        @(negedge clk);
        check("zero_count_err", {done, err, core_rst_n, busy}, 4'b0100);

        // Four words with randomly gapped byte_valid
        bq.delete();
        for (int i = 0; i < 16; i++) bq.push_back(8'($urandom_range(0, 255)));
        for (int w = 0; w < 4; w++) begin
            exp_addr_q.push_back(32'h1000 + 32'(4 * w));
            exp_data_q.push_back(model_word(w));
        end
        do_start(32'h1000, 16'd4);
        send(0, 16, 1'b1);
        wait_end("random_valid", 1'b1);

        // start pulsed mid-load has no effect
        bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        exp_addr_q.push_back(32'h200); exp_data_q.push_back(32'hDDCC_BBAA);
        do_start(32'h200, 16'd1);
        send(0, 2, 1'b0);
        @(posedge clk); #2;
        start = 1'b1; base_addr = 32'h300; word_count = 16'd5;
        @(posedge clk); #2;
        start = 1'b0;
        send(2, 2, 1'b0);
        wait_end("start_ignored", 1'b1);
        check("addr_hold", mem_addr, 32'h200);
        check("data_hold", mem_wdata, 32'hDDCC_BBAA);

        // Timeout after two bytes
        bq = '{8'h11, 8'h22};
        do_start(32'h500, 16'd3);
        send(0, 2, 1'b0);
        for (int k = 0; k < TMO; k++) begin
            @(negedge clk);
            check("timeout_early", err, 1'b0);
        end
        @(negedge clk);
        check("timeout_err", {err, done, core_rst_n, busy}, 4'b1000);

        // Address wrap past 2^32
        bq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        exp_addr_q.push_back(32'hFFFF_FFFC); exp_data_q.push_back(32'h0403_0201);
        exp_addr_q.push_back(32'h0000_0000); exp_data_q.push_back(32'h0807_0605);
        do_start(32'hFFFF_FFFC, 16'd2);
        send(0, 8, 1'b0);
        wait_end("wrap", 1'b1);

        // Reset while the last byte of a word is being offered
        bq = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27, 8'h28};
        exp_addr_q.push_back(32'h400); exp_data_q.push_back(32'h2423_2221);
        do_start(32'h400, 16'd2);
        send(0, 7, 1'b0);
        @(posedge clk); #2;
        byte_valid = 1'b1;
        byte_data  = bq[7];
        rst        = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        byte_valid = 1'b0;
        rst        = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("post_reset_idle", {busy, done, err, core_rst_n, mem_we}, 5'd0);
        end
        check("reset_writes_left", exp_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
